int_dispatcher: RTL and testbench

INT_DISPATCHER -- requirements
Module: int_dispatcher

---
 rtl/int_dispatcher_if.sv | 30 +++
 rtl/int_dispatcher.sv | 85 ++++++++
 tb/tb_int_dispatcher.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_dispatcher_if.sv
// Bundle between the CPU core and the interrupt dispatcher.
// The CPU side drives requests and instruction-boundary status; the dispatcher returns PC redirects.
interface int_dispatcher_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 10
);
   logic [WIDTH-1:0] min_bit_s;
   logic [WIDTH-1:0] min_bit_a;
   logic [AW-1:0]    dir;
   logic [AW-1:0]    pc;
   logic             instr_done;
   logic             ret_i;
   logic             int_en;
   logic [WIDTH-1:0] s_calli;
   logic [WIDTH-1:0] s_reti;
   logic             pc_load;
   logic [AW-1:0]    pc_new;
   logic             busy;
   logic             ret_err;

   modport master (
      output min_bit_s, min_bit_a, dir, pc, instr_done, ret_i, int_en,
      input  s_calli, s_reti, pc_load, pc_new, busy, ret_err
   );

   modport slave (
      input  min_bit_s, min_bit_a, dir, pc, instr_done, ret_i, int_en,
      output s_calli, s_reti, pc_load, pc_new, busy, ret_err
   );
endinterface

// File: rtl/int_dispatcher.sv
// Interrupt entry/return sequencer with a LIFO return-address stack.
// Entry: CALL (pulse s_calli, push pc) then JUMP (load vector). Return: RET (pulse s_reti, pop).
module int_dispatcher #(
   parameter int WIDTH = 8,
   parameter int AW    = 10
) (
   input logic           clk,
   input logic           reset,
   int_dispatcher_if.slave bus
);
   localparam int SPW = $clog2(WIDTH + 1);
   localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [SPW-1:0] FULL = SPW'(WIDTH);

   typedef enum logic [1:0] {IDLE, CALL, JUMP, RET} state_t;

   state_t         state;
   logic [AW-1:0]  stack [WIDTH];
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_dec;
   logic [AW-1:0]  ret_pc;
   logic           preempt;

   // Requests are one-hot, so a lower bit index is simply a smaller value.
   always_comb begin
      preempt = (bus.min_bit_s != '0) &&
                ((bus.min_bit_a == '0) || (bus.min_bit_s < bus.min_bit_a));
   end

   assign sp_dec = sp - 1'b1;

   // The vector address arrives one cycle after s_calli, so JUMP passes dir straight through.
   assign bus.pc_new = (state == JUMP) ? bus.dir : ret_pc;
   assign bus.busy   = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sp          <= '0;
         ret_pc      <= '0;
         bus.s_calli <= '0;
         bus.s_reti  <= '0;
         bus.pc_load <= 1'b0;
         bus.ret_err <= 1'b0;
      end else begin
         bus.s_calli <= '0;
         bus.s_reti  <= '0;
         bus.pc_load <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.instr_done) begin
                  if (bus.ret_i) begin
                     if (sp != '0) begin
                        state       <= RET;
                        bus.s_reti  <= bus.min_bit_a;
                        bus.pc_load <= 1'b1;
                        ret_pc      <= stack[sp_dec[IW-1:0]];
                        sp          <= sp_dec;
                     end else begin
                        bus.ret_err <= 1'b1;
                     end
                  end else if (bus.int_en && preempt) begin
                     state       <= CALL;
                     bus.s_calli <= bus.min_bit_s;
                     // The return address is pushed on the accepting edge, which is the pc latched at entry.
                     if (sp == FULL) begin
                        bus.ret_err <= 1'b1;
                     end else begin
                        stack[sp[IW-1:0]] <= bus.pc;
                        sp                <= sp + 1'b1;
                     end
                  end
               end
            end
            CALL: begin
               state       <= JUMP;
               bus.pc_load <= 1'b1;
            end
            JUMP:    state <= IDLE;
            RET:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_int_dispatcher.sv
// Randomized and directed checks of int_dispatcher against a transaction-level reference model.
module tb_int_dispatcher;
   localparam int WIDTH = 8;
   localparam int AW    = 10;

   typedef struct {
      logic [WIDTH-1:0] calli;
      logic [WIDTH-1:0] reti;
      logic             load;
      logic             jump;
      logic             busy;
      logic [AW-1:0]    newpc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int_dispatcher_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
   int_dispatcher #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int            n_vec = 0;
   int            n_err = 0;
   exp_t          e;
   exp_t          sched[$];
   logic [AW-1:0] stk[$];
   logic          m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int first_idx(input logic [WIDTH-1:0] v);
      for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
      return WIDTH;
   endfunction

   function automatic exp_t quiet();
      exp_t q;
      q.calli = '0; q.reti = '0; q.load = 1'b0; q.jump = 1'b0; q.busy = 1'b0; q.newpc = '0;
      return q;
   endfunction

   function automatic logic [WIDTH-1:0] rand_onehot();
      logic [WIDTH-1:0] v = '0;
      int k = $urandom_range(0, WIDTH);
      if (k > 0) v[k-1] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      sched.delete();
      stk.delete();
      m_err = 1'b0;
      e     = quiet();
   endtask

   // What the next clock edge must produce: scheduled follow-on cycles first, else the IDLE rules.
   task automatic decide(input logic [WIDTH-1:0] s, a, input logic [AW-1:0] p,
                         input logic done, ret, en);
      exp_t n = quiet();
      exp_t j = quiet();
      if (sched.size() > 0) begin
         n = sched.pop_front();
      end else if (done) begin
         if (ret) begin
            if (stk.size() > 0) begin
               n.reti = a; n.load = 1'b1; n.busy = 1'b1; n.newpc = stk.pop_back();
               sched.push_back(quiet());
            end else begin
               m_err = 1'b1;
            end
         end else if (en && s != '0 && first_idx(s) < first_idx(a)) begin
            n.calli = s; n.busy = 1'b1;
            if (stk.size() < WIDTH) stk.push_back(p);
            else m_err = 1'b1;
            j.load = 1'b1; j.jump = 1'b1; j.busy = 1'b1;
            sched.push_back(j);
            sched.push_back(quiet());
         end
      end
      e = n;
   endtask

   task automatic verify();
      check("s_calli", 32'(bus.s_calli), 32'(e.calli));
      check("s_reti",  32'(bus.s_reti),  32'(e.reti));
      check("pc_load", 32'(bus.pc_load), 32'(e.load));
      check("busy",    32'(bus.busy),    32'(e.busy));
      check("ret_err", 32'(bus.ret_err), 32'(m_err));
      if (e.load) check("pc_new", 32'(bus.pc_new), e.jump ? 32'(bus.dir) : 32'(e.newpc));
   endtask

   task automatic cycle(input logic [WIDTH-1:0] s, a, input logic [AW-1:0] p, d,
                        input logic done, ret, en);
      @(negedge clk);
      verify();
      bus.min_bit_s  = s;
      bus.min_bit_a  = a;
      bus.pc         = p;
      bus.dir        = d;
      bus.instr_done = done;
      bus.ret_i      = ret;
      bus.int_en     = en;
      decide(s, a, p, done, ret, en);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0, '0, AW'($urandom), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      bus.min_bit_s = '0; bus.min_bit_a = '0; bus.pc = '0; bus.dir = '0;
      bus.instr_done = 1'b0; bus.ret_i = 1'b0; bus.int_en = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_calli", 32'(bus.s_calli), 0);
      check("rst_reti",  32'(bus.s_reti),  0);
      check("rst_load",  32'(bus.pc_load), 0);
      check("rst_pcnew", 32'(bus.pc_new),  0);
      check("rst_busy",  32'(bus.busy),    0);
      check("rst_err",   32'(bus.ret_err), 0);
      reset = 1'b1;

      // Basic entry; pending request changes during CALL must be ignored.
      cycle(8'h04, 8'h00, 10'h023, 10'h155, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("entry_calli", 32'(bus.s_calli), 32'h04);
      cycle(8'h01, 8'h00, 10'h000, 10'h155, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("entry_load",  32'(bus.pc_load), 1);
      check("entry_pcnew", 32'(bus.pc_new),  32'h155);
      idle(2);

      // Nesting: higher priority preempts, lower does not.
      cycle(8'h01, 8'h04, 10'h040, 10'h0A0, 1'b1, 1'b0, 1'b1);
      idle(3);
      cycle(8'h08, 8'h04, 10'h050, 10'h0B0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("nest_block", 32'(bus.busy), 0);

      // Returns unwind in LIFO order.
      cycle(8'h00, 8'h01, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("ret1_pcnew", 32'(bus.pc_new), 32'h040);
      idle(1);
      cycle(8'h00, 8'h04, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("ret2_reti",  32'(bus.s_reti), 32'h04);
      check("ret2_pcnew", 32'(bus.pc_new), 32'h023);
      idle(2);

      // RETI and a higher-priority request together: RET first, CALL on a later boundary.
      cycle(8'h04, 8'h00, 10'h077, 10'h1C0, 1'b1, 1'b0, 1'b1);
      idle(3);
      cycle(8'h01, 8'h04, 10'h078, 10'h1C1, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("sim_reti",  32'(bus.s_reti),  32'h04);
      check("sim_calli", 32'(bus.s_calli), 0);
      cycle(8'h01, 8'h00, 10'h078, 10'h1C1, 1'b1, 1'b0, 1'b1);
      cycle(8'h01, 8'h00, 10'h078, 10'h1C1, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("sim_calli2", 32'(bus.s_calli), 32'h01);
      idle(3);

      // Entry masked by int_en, RETI still honoured.
      cycle(8'h01, 8'h00, 10'h099, 10'h000, 1'b1, 1'b0, 1'b0);
      cycle(8'h00, 8'h01, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0);
      idle(3);

      // Forced overflow: ninth push is dropped and flags ret_err.
      do_reset();
      for (int i = 0; i < WIDTH + 1; i++) begin
         cycle(8'h80, 8'h00, AW'(i + 10'h100), AW'($urandom), 1'b1, 1'b0, 1'b1);
         idle(2);
      end
      idle(1);
      check("ovf_err", 32'(bus.ret_err), 1);
      for (int i = 0; i < 3; i++) begin
         cycle(8'h00, 8'h80, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1);
         idle(1);
      end

      // Reset in JUMP aborts and empties the stack; a following RETI is an error.
      do_reset();
      cycle(8'h02, 8'h00, 10'h111, 10'h2AA, 1'b1, 1'b0, 1'b1);
      cycle(8'h00, 8'h00, 10'h000, 10'h2AA, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #2;
      check("jump_load", 32'(bus.pc_load), 1);
      reset = 1'b0;
      #1;
      check("abort_load",  32'(bus.pc_load), 0);
      check("abort_busy",  32'(bus.busy),    0);
      check("abort_pcnew", 32'(bus.pc_new),  0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      cycle(8'h00, 8'h02, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("empty_err",  32'(bus.ret_err), 1);
      check("empty_load", 32'(bus.pc_load), 0);
      check("empty_reti", 32'(bus.s_reti),  0);
      idle(4);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cycle(rand_onehot(), rand_onehot(), AW'($urandom), AW'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 4) != 0));
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
